// File: rtl/pp_acc_pkg.sv
// Shared types, default sizes and sign-extension correction for pp_accumulator.
package pp_acc_pkg;

  localparam int PP_W_DEF   = 10;
  localparam int NUM_PP_DEF = 4;
  localparam int PROD_W_DEF = 2 * (PP_W_DEF - 2);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } accState_e;

  // Each MSB-inverted addend carries a bias of 2^(ppW-1) at its shifted weight.
  // This returns minus the sum of those biases for digits 0..idx, so adding it
  // once turns the biased sum back into the true signed sum.
  function automatic logic [63:0] signCorr(input int idx, input int ppW);
    logic [63:0] s;
    s = '0;
    for (int j = 0; j <= idx; j++) s += 64'd1 << (ppW - 1 + 2 * j);
    return ~s + 64'd1;
  endfunction

  localparam logic [63:0] SIGN_CONST = signCorr(NUM_PP_DEF - 1, PP_W_DEF);

endpackage

// File: rtl/pp_accumulator_pp_align.sv
// pp_align: turns one Booth partial product into a shifted, MSB-inverted addend.
module pp_align
  import pp_acc_pkg::*;
#(
  parameter int PP_W   = PP_W_DEF,
  parameter int PROD_W = PROD_W_DEF,
  parameter int IDX_W  = 2
) (
  input  logic [PP_W-1:0]   ppData,
  input  logic              ppNeg,
  input  logic [IDX_W-1:0]  idx,
  output logic [PROD_W-1:0] addend
);

  logic [PROD_W-1:0] base;
  logic [PROD_W-1:0] negBit;

  // Inverting the MSB makes the value unsigned-positive; the bias is removed later.
  assign base   = {{(PROD_W-PP_W){1'b0}}, ~ppData[PP_W-1], ppData[PP_W-2:0]};
  assign negBit = {{(PROD_W-1){1'b0}}, ppNeg};
  assign addend = (base + negBit) << {idx, 1'b0};

endmodule

// File: rtl/pp_accumulator.sv
// Radix-4 Booth partial-product accumulator with valid/ready on both sides.
// Optional sticky protocol-error output enabled by define PP_ACC_ERR_EN.
module pp_accumulator
  import pp_acc_pkg::*;
#(
  parameter int PP_W   = PP_W_DEF,
  parameter int NUM_PP = NUM_PP_DEF,
  parameter int PROD_W = 2 * (PP_W - 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pp_valid,
  output logic              pp_ready,
  input  logic [PP_W-1:0]   pp_data,
  input  logic              pp_neg,
  input  logic              pp_last,
  output logic              prod_valid,
  input  logic              prod_ready,
  output logic [PROD_W-1:0] prod
`ifdef PP_ACC_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int IDX_W = (NUM_PP > 1) ? $clog2(NUM_PP) : 1;

  accState_e         state, stateNext;
  logic [IDX_W-1:0]  idx;
  logic [PROD_W-1:0] acc, accNext, addend, prodReg;
  logic [PROD_W-1:0] corrTab [NUM_PP];
  logic              ppHs, prodHs, atLastIdx, finish;

  pp_align #(.PP_W(PP_W), .PROD_W(PROD_W), .IDX_W(IDX_W)) uAlign (
    .ppData (pp_data),
    .ppNeg  (pp_neg),
    .idx    (idx),
    .addend (addend)
  );

  // Bias correction depends only on how many digits were actually summed.
  for (genvar g = 0; g < NUM_PP; g++) begin : gCorr
    localparam logic [63:0] C = signCorr(g, PP_W);
    assign corrTab[g] = C[PROD_W-1:0];
  end

  assign ppHs      = pp_valid & pp_ready;
  assign prodHs    = prod_valid & prod_ready;
  assign atLastIdx = (idx == IDX_W'(NUM_PP - 1));
  assign finish    = ppHs & (pp_last | atLastIdx);
  assign accNext   = acc + addend;
  assign prod      = prodReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    pp_ready   = 1'b0;
    prod_valid = 1'b0;
    case (state)
      ACCUM: begin
        pp_ready = ~rst;
        if (finish) stateNext = DONE;
      end
      DONE: begin
        prod_valid = 1'b1;
        if (prodHs) stateNext = ACCUM;
      end
      default: stateNext = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      idx     <= '0;
      prodReg <= '0;
    end else if (prodHs) begin
      acc <= '0;
      idx <= '0;
    end else if (finish) begin
      acc     <= accNext;
      prodReg <= accNext + corrTab[idx];
    end else if (ppHs) begin
      acc <= accNext;
      idx <= idx + IDX_W'(1);
    end
  end

`ifdef PP_ACC_ERR_EN
  // A full-length operation must carry pp_last on its final digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            err <= 1'b0;
    else if (ppHs & atLastIdx & ~pp_last) err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_pp_accumulator.sv
// Self-checking bench for pp_accumulator: directed cases plus random operations.
module tb_pp_accumulator;
  localparam int PP_W   = 10;
  localparam int NUM_PP = 4;
  localparam int PROD_W = 16;

  logic clk = 0, rst = 1;
  logic pp_valid = 0, pp_neg = 0, pp_last = 0, prod_ready = 0;
  logic [PP_W-1:0] pp_data = '0;
  logic pp_ready, prod_valid;
  logic [PROD_W-1:0] prod;
`ifdef PP_ACC_ERR_EN
  logic err;
`endif

  int checks = 0, errors = 0;
  logic [PP_W-1:0] qd[$];
  bit qn[$];

  pp_accumulator #(.PP_W(PP_W), .NUM_PP(NUM_PP), .PROD_W(PROD_W)) dut (
    .clk(clk), .rst(rst), .pp_valid(pp_valid), .pp_ready(pp_ready),
    .pp_data(pp_data), .pp_neg(pp_neg), .pp_last(pp_last),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .prod(prod)
`ifdef PP_ACC_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed arithmetic over the digits offered since the last product.
  function automatic logic [PROD_W-1:0] refProd();
    longint s = 0;
    for (int i = 0; i < qd.size(); i++) begin
      logic signed [PP_W-1:0] v;
      v = qd[i];
      s += (longint'(v) + longint'(qn[i])) * (longint'(1) << (2 * i));
    end
    return s[PROD_W-1:0];
  endfunction

  task automatic sendPp(input logic [PP_W-1:0] d, input bit n, input bit l);
    int k;
    bit fin;
    @(negedge clk);
    pp_valid = 1; pp_data = d; pp_neg = n; pp_last = l;
    k = 0;
    while (!pp_ready && k < 20) begin @(negedge clk); k++; end
    if (k == 20) check("pp_ready_timeout", 32'(pp_ready), 32'd1);
    fin = l || (qd.size() == NUM_PP - 1);
    qd.push_back(d); qn.push_back(n);
    @(posedge clk); #1;
    pp_valid = 0; pp_last = 0;
    if (fin) begin
      @(negedge clk);
      check("latency1", 32'(prod_valid), 32'd1);
    end
  endtask

  task automatic getProd(input string tag);
    int k = 0;
    while (!prod_valid && k < 20) begin @(negedge clk); k++; end
    check({tag, "_valid"}, 32'(prod_valid), 32'd1);
    check(tag, 32'(prod), 32'(refProd()));
    prod_ready = 1;
    @(posedge clk); #1;
    prod_ready = 0;
    qd.delete(); qn.delete();
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_pp_ready", 32'(pp_ready), 32'd0);
    check("rst_prod_valid", 32'(prod_valid), 32'd0);
    check("rst_prod", 32'(prod), 32'd0);
`ifdef PP_ACC_ERR_EN
    check("rst_err", 32'(err), 32'd0);
`endif
    rst = 0;
    @(negedge clk);
    check("idle_pp_ready", 32'(pp_ready), 32'd1);

    // 3*5
    sendPp(10'h003, 0, 0);
    sendPp(10'h003, 0, 1);
    check("mul3x5_exp", 32'(refProd()), 32'h000F);
    getProd("mul3x5");

    // 7*(-1)
    sendPp(10'h3F8, 1, 0);
    sendPp(10'h000, 0, 0);
    sendPp(10'h000, 0, 0);
    sendPp(10'h000, 0, 1);
    getProd("mul7xm1");
    check("mul7xm1_const", 32'(prod), 32'hFFF9);

    // (-128)*(-128)
    sendPp(10'h000, 0, 0);
    sendPp(10'h000, 0, 0);
    sendPp(10'h000, 0, 0);
    sendPp(10'h100, 0, 1);
    getProd("mulm128sq");
    check("mulm128sq_const", 32'(prod), 32'h4000);

    // Backpressure: product held with a pp waiting
    sendPp(10'h3FF, 0, 1);
    @(negedge clk);
    pp_valid = 1; pp_data = 10'h005; pp_neg = 0; pp_last = 1;
    for (int c = 0; c < 5; c++) begin
      check("bp_prod", 32'(prod), 32'(refProd()));
      check("bp_pp_ready", 32'(pp_ready), 32'd0);
      check("bp_prod_valid", 32'(prod_valid), 32'd1);
      @(negedge clk);
    end
    prod_ready = 1;
    @(posedge clk); #1;
    prod_ready = 0;
    qd.delete(); qn.delete();
    @(negedge clk);
    check("bp_accept", 32'(pp_ready), 32'd1);
    qd.push_back(10'h005); qn.push_back(0);
    @(posedge clk); #1;
    pp_valid = 0; pp_last = 0;
    getProd("bp_next_idx0");
    check("bp_next_const", 32'(prod), 32'h0005);

    // Reset mid-operation
    sendPp(10'h07F, 1, 0);
    sendPp(10'h011, 0, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("midrst_pp_ready", 32'(pp_ready), 32'd0);
    check("midrst_prod", 32'(prod), 32'd0);
    rst = 0;
    qd.delete(); qn.delete();
    sendPp(10'h003, 0, 1);
    getProd("midrst");
    check("midrst_const", 32'(prod), 32'h0003);

    // Random operations, random gaps and product backpressure
    for (int op = 0; op < 40; op++) begin
      int n;
      n = $urandom_range(1, NUM_PP);
      for (int i = 0; i < n; i++) begin
        bit l;
`ifdef PP_ACC_ERR_EN
        l = (i == n - 1);
`else
        l = (i == n - 1) && ((n < NUM_PP) || $urandom_range(0, 1) == 1);
`endif
        repeat ($urandom_range(0, 2)) @(negedge clk);
        sendPp(PP_W'($urandom), bit'($urandom_range(0, 1)), l);
      end
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check("rnd_hold_ready", 32'(pp_ready), 32'd0);
      end
      getProd("rnd");
    end

`ifdef PP_ACC_ERR_EN
    check("err_before", 32'(err), 32'd0);
    for (int i = 0; i < NUM_PP; i++) sendPp(10'h001, 0, 0);
    getProd("err_prod");
    check("err_set", 32'(err), 32'd1);
    sendPp(10'h002, 0, 1);
    getProd("err_after");
    check("err_sticky", 32'(err), 32'd1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("err_clear", 32'(err), 32'd0);
    rst = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pp_accumulator.md
PP_ACCUMULATOR -- requirements
Module: pp_accumulator

Interface
REQ-001 SHALL have parameter PP_W, default 10, meaning partial-product width in bits, two's complement.
REQ-002 SHALL have parameter NUM_PP, default 4, meaning the maximum number of radix-4 Booth partial products per product.
REQ-003 SHALL have parameter PROD_W, default 16, meaning product width, fixed at 2*(PP_W-2).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port pp_valid, input, 1 bit: a partial product is offered.
REQ-007 SHALL have port pp_ready, output, 1 bit: the block accepts the offered partial product.
REQ-008 SHALL have port pp_data, input, PP_W bits: Booth partial product, one's-complemented when the Booth digit is negative.
REQ-009 SHALL have port pp_neg, input, 1 bit: negation bit, adds +1 at the partial product's LSB weight.
REQ-010 SHALL have port pp_last, input, 1 bit: marks the final partial product of the operation.
REQ-011 SHALL have port prod_valid, output, 1 bit: the product is presented.
REQ-012 SHALL have port prod_ready, input, 1 bit: the downstream consumer takes the product.
REQ-013 SHALL have port prod, output, PROD_W bits: the signed product.
REQ-014 SHALL have port err, output, 1 bit: sticky protocol error; present only with PP_ACC_ERR_EN.

Function
REQ-015 SHALL transfer a partial product on a cycle where pp_valid and pp_ready are both 1; the product handshake SHALL be prod_valid and prod_ready both 1.
REQ-016 SHALL compute prod = sum over i of (sext(pp_data_i) + pp_neg_i) << 2i, modulo 2^PROD_W, where i is the 0-based handshake index since the last product.
REQ-017 SHALL absorb sign extension internally: inverted-MSB encoding plus a precomputed constant, no per-product wide sign replication.
REQ-018 SHALL implement state machine ACCUM / DONE: pp_ready = 1 only in ACCUM, prod_valid = 1 only in DONE.
REQ-019 SHALL, in ACCUM, advance index 0..NUM_PP-1 on each handshake; on a pp_last handshake or at index NUM_PP-1, move to DONE with prod valid the next cycle (latency 1).
REQ-020 SHALL treat a pp_last at index < NUM_PP-1 as early termination, remaining digits zero.
REQ-021 SHALL hold prod and prod_valid stable in DONE until prod_ready; on that handshake clear the accumulator and index and return to ACCUM.
REQ-022 SHALL sustain one partial product per cycle in ACCUM; pp_valid while in DONE is not accepted (backpressure).
REQ-023 SHALL never change state on a cycle with pp_valid = 0 in ACCUM.

Reset
REQ-024 SHALL, while rst = 1, force state ACCUM, index 0, accumulator 0, prod 0, prod_valid 0, pp_ready 0, err 0.
REQ-025 SHALL, on rst mid-operation, discard the partial sum; the first handshake after release is index 0.

Configuration
REQ-026 SHALL, with PP_ACC_ERR_EN defined, set err sticky when a handshake at index NUM_PP-1 has pp_last = 0; it clears only on rst, and the product is still produced.
REQ-027 SHALL, without PP_ACC_ERR_EN, omit the err port and the check entirely.

Structure
REQ-028 SHALL place the state enum, the PP_W / NUM_PP / PROD_W defaults and the sign-extension constant in shared package pp_acc_pkg.
REQ-029 SHALL contain one combinational sub-module, pp_align, which converts pp_data/pp_neg and the index into the shifted, MSB-inverted PROD_W-bit addend.

Verification
REQ-030 SHALL test 3*5: pp0 = 0x003, pp1 = 0x003 with last, neg 0 -> prod = 0x000F one cycle later.
REQ-031 SHALL test 7*(-1): pp0 = 0x3F8 with neg 1, pp1..pp3 = 0x000, pp3 last -> prod = 0xFFF9.
REQ-032 SHALL test (-128)*(-128): pp0..pp2 = 0, pp3 = 0x100 with last -> prod = 0x4000.
REQ-033 SHALL test backpressure: prod_ready = 0 for 5 cycles with pp_valid held high -> prod stable, pp_ready 0, no pp consumed; the next pp is accepted as index 0 after the handshake.
REQ-034 SHALL test reset mid-operation: rst after 2 pp, then pp0 = 0x003 with last -> prod = 0x0003.
REQ-035 SHALL test the error check with PP_ACC_ERR_EN: 4 pp without last -> product still valid, err = 1 and staying 1 until rst.
